// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide, one bit per cycle.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_f3;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic              r_neg;
  logic              r_rneg;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_result;

  logic              w_is_div;
  logic              w_a_sgn;
  logic              w_b_sgn;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_div0;
  logic              w_ovf;
  logic              w_fast;
  logic [XLEN-1:0]   w_fast_res;
  logic              w_accept;

  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_sh;
  logic [XLEN+1:0]   w_diff;
  logic              w_ge;
  logic [XLEN-1:0]   w_nhi;
  logic [XLEN-1:0]   w_nlo;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_final;

  // Decode operand signedness, magnitudes and the single-cycle special cases
  always_comb begin
    w_is_div = funct3[2];
    w_a_sgn  = w_is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
    w_b_sgn  = w_is_div ? ~funct3[0] : ~funct3[1];
    w_a_neg  = w_a_sgn & op_a[XLEN-1];
    w_b_neg  = w_b_sgn & op_b[XLEN-1];
    w_a_mag  = w_a_neg ? (~op_a + 1'b1) : op_a;
    w_b_mag  = w_b_neg ? (~op_b + 1'b1) : op_b;
    w_div0   = w_is_div & (op_b == '0);
    w_ovf    = w_is_div & ~funct3[0]
             & (op_a == {1'b1, {(XLEN-1){1'b0}}})
             & (&op_b);
    w_fast   = w_div0 | w_ovf;
    w_fast_res = '0;
    if (w_div0) w_fast_res = funct3[1] ? op_a : '1;
    else if (w_ovf) w_fast_res = funct3[1] ? '0 : op_a;
    w_accept = (r_state == S_IDLE) & start & ~flush;
  end

  // One iteration step and final sign fix-up / result selection
  always_comb begin
    w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
    w_sh   = {r_hi, r_lo[XLEN-1]};
    w_diff = {1'b0, w_sh} - {2'b00, r_b};
    w_ge   = ~|w_diff[XLEN+1:XLEN];
    if (r_f3[2]) begin
      w_nhi = w_ge ? w_diff[XLEN-1:0] : w_sh[XLEN-1:0];
      w_nlo = {r_lo[XLEN-2:0], w_ge};
    end else begin
      w_nhi = w_sum[XLEN:1];
      w_nlo = {w_sum[0], r_lo[XLEN-1:1]};
    end
    w_prod   = {w_nhi, w_nlo};
    w_prod_s = r_neg ? (~w_prod + 1'b1) : w_prod;
    w_quo    = r_neg ? (~w_nlo + 1'b1) : w_nlo;
    w_rem    = r_rneg ? (~w_nhi + 1'b1) : w_nhi;
    if (r_f3[2])
      w_final = r_f3[1] ? w_rem : w_quo;
    else if (r_f3[1:0] == 2'b00)
      w_final = w_prod_s[XLEN-1:0];
    else
      w_final = w_prod_s[2*XLEN-1:XLEN];
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; flush always wins
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_fast ? S_DONE : S_BUSY;
      S_BUSY: if (r_cnt == '0) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  // Outputs decoded from state
  always_comb begin
    busy         = (r_state == S_BUSY);
    result_valid = (r_state == S_DONE);
    stall        = (start & (r_state == S_IDLE) & ~w_fast) | busy;
  end

  // Operand capture, iteration datapath and result register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_f3     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_neg    <= 1'b0;
      r_rneg   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_result <= '0;
    end else if (!flush) begin
      if (w_accept) begin
        r_f3   <= funct3;
        r_a    <= w_a_mag;
        r_b    <= w_b_mag;
        r_neg  <= w_a_neg ^ w_b_neg;
        r_rneg <= w_a_neg;
        r_hi   <= '0;
        r_lo   <= w_is_div ? w_a_mag : w_b_mag;
        r_cnt  <= CW'(XLEN - 1);
        if (w_fast) r_result <= w_fast_res;
      end else if (r_state == S_BUSY) begin
        r_hi  <= w_nhi;
        r_lo  <= w_nlo;
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == '0) r_result <= w_final;
      end
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer.
// Scoreboard queue of expected results, one task per scenario.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        stall;
  logic        busy;
  logic        result_valid;
  logic [31:0] result;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] q_exp[$];

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .funct3(funct3),
    .op_a(op_a),
    .op_b(op_b),
    .flush(flush),
    .stall(stall),
    .busy(busy),
    .result_valid(result_valid),
    .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] f,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, p;
    logic [63:0] up;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'($signed(a) / $signed(b));
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return 32'($signed(a) % $signed(b));
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic run_op(input string nm, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit fast);
    int cyc;
    int want;
    bit bad_stall;
    logic [31:0] e;
    q_exp.push_back(exp);
    want = fast ? 1 : 33;
    @(posedge clk); #1;
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    #1;
    n_checks++;
    if (stall !== !fast) begin
      n_errors++;
      $display("FAIL %s stall_c0: got %b want %b", nm, stall, !fast);
    end
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    bad_stall = 0;
    while (result_valid !== 1'b1 && cyc < 80) begin
      if (stall !== 1'b1 || busy !== 1'b1) bad_stall = 1;
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (result_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL %s timeout: no result_valid after %0d cycles", nm, cyc);
      void'(q_exp.pop_front());
      return;
    end
    n_checks++;
    if (cyc != want || bad_stall) begin
      n_errors++;
      $display("FAIL %s latency: got %0d want %0d stall_ok=%b",
               nm, cyc, want, !bad_stall);
    end
    e = q_exp.pop_front();
    n_checks++;
    if (result !== e || stall !== 1'b0) begin
      n_errors++;
      $display("FAIL %s result: got %h want %h (stall %b)", nm, result, e, stall);
    end
    @(posedge clk); #1;
    n_checks++;
    if (result_valid !== 1'b0 || result !== e) begin
      n_errors++;
      $display("FAIL %s pulse: valid %b result %h want 0/%h",
               nm, result_valid, result, e);
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({busy, stall, result_valid} !== 3'b000 || result !== 32'h0) begin
      n_errors++;
      $display("FAIL reset: busy %b stall %b valid %b result %h want 0",
               busy, stall, result_valid, result);
    end
  endtask

  task automatic test_mul();
    run_op("mul_7x6", 3'b000, 32'd7, 32'd6, 32'd42, 0);
    run_op("mulh_m1", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 0);
    run_op("mulhu_ff", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run_op("mulhsu_m1x2", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 0);
    run_op("mul_neg", 3'b000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 0);
  endtask

  task automatic test_div();
    run_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    run_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
    run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 0);
    run_op("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 0);
  endtask

  task automatic test_fast();
    run_op("divu_by0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu_by0", 3'b111, 32'd5, 32'd0, 32'd5, 1);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
    run_op("rem_by0", 3'b110, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 1);
  endtask

  task automatic test_flush();
    logic [31:0] prev;
    bit seen;
    prev = result;
    @(posedge clk); #1;
    funct3 = 3'b000; op_a = 32'd12345; op_b = 32'd678;
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_beats_start: busy %b want 0", busy);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 2; i <= 10; i++) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_busy_c10: busy %b want 1", busy);
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_checks++;
    if ({busy, stall, result_valid} !== 3'b000) begin
      n_errors++;
      $display("FAIL flush_idle: busy %b stall %b valid %b want 000",
               busy, stall, result_valid);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (result_valid === 1'b1) seen = 1;
    end
    n_checks++;
    if (seen || result !== prev) begin
      n_errors++;
      $display("FAIL flush_no_pulse: pulse %b result %h want 0/%h",
               seen, result, prev);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    funct3 = 3'b000; op_a = 32'd1000; op_b = 32'd1000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    n_checks++;
    if (busy !== 1'b1 || result === 32'h0) begin
      n_errors++;
      $display("FAIL reset_mid_pre: busy %b result %h want 1/nonzero", busy, result);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, stall, result_valid} !== 3'b000 || result !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_mid: busy %b stall %b valid %b result %h want 0",
               busy, stall, result_valid, result);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    run_op("mul_3x3", 3'b000, 32'd3, 32'd3, 32'd9, 0);
  endtask

  task automatic test_back_to_back();
    int cyc;
    int pulses;
    logic [31:0] e;
    q_exp.push_back(32'hFFFF_FFFE);
    q_exp.push_back(32'hFFFF_FFFE);
    @(posedge clk); #1;
    funct3 = 3'b011; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF;
    start = 1'b1;
    cyc = 0;
    pulses = 0;
    while (pulses < 2 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 34) begin
        n_checks++;
        if (stall !== 1'b1 || busy !== 1'b0) begin
          n_errors++;
          $display("FAIL b2b_restart: stall %b busy %b want 1/0", stall, busy);
        end
      end
      if (result_valid === 1'b1) begin
        pulses++;
        e = q_exp.pop_front();
        n_checks++;
        if (result !== e || cyc != (pulses == 1 ? 33 : 67)) begin
          n_errors++;
          $display("FAIL b2b_%0d: result %h cycle %0d want %h/%0d",
                   pulses, result, cyc, e, pulses == 1 ? 33 : 67);
        end
      end
    end
    start = 1'b0;
    n_checks++;
    if (pulses != 2) begin
      n_errors++;
      $display("FAIL b2b_timeout: pulses %0d want 2", pulses);
    end
    while (q_exp.size() > 2) void'(q_exp.pop_front());
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    bit fast;
    for (int i = 0; i < 24; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      if (i % 6 == 5) b = 32'($urandom_range(1, 15));
      fast = f[2] && (b == 0 ||
             (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      run_op("random", f, a, b, model(f, a, b), fast);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0;
    funct3 = 3'b000; op_a = 32'h0; op_b = 32'h0;
    #12;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    test_mul();
    test_div();
    test_fast();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    n_checks++;
    if (q_exp.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_left: %0d entries want 0", q_exp.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
